reg_arbiter: RTL
================

# reg_arbiter

- Round-robin arbiter that shares one WIDTH-bit output register, built from D flip-flops, among N_REQ requesters.
- Each cycle it grants at most one requester, captures that requester's data into the register and reports which requester owns the current value.
- Sits between several producer blocks and any downstream logic that consumes a single registered value.

## Interface
Parameters:
- N_REQ, 4: number of requesters; minimum 2.
- WIDTH, 8: data width of each requester and of the shared register.
- MAX_LOCK, 4: maximum consecutive locked grants; only used with ARB_LOCK_EN.

Ports:
- clk  input  1: single clock; all state updates on posedge clk.
- reset  input  1: synchronous, active-high reset, sampled on posedge clk.
- req  input  N_REQ: per-requester write request.
- wdata  input  N_REQ×WIDTH: packed array; wdata[i] belongs to requester i.
- lock  input  N_REQ: per-requester lock request; present only with ARB_LOCK_EN.
- gnt  output  N_REQ: one-hot (or zero) grant, combinational.
- q  output  WIDTH: shared register value.
- q_valid  output  1: one-cycle pulse, high the cycle after a write.
- owner  output  $clog2(N_REQ): index of the requester whose data is in q.

## Operation
- Sequential state:
  - ptr: last granted index.
  - q, q_valid, owner.
  - With ARB_LOCK_EN: lock_active and lock_cnt.
- Arbitration (combinational):
  - Search req starting at (ptr+1) mod N_REQ and wrapping around.
  - The first set bit wins and gnt is that bit, one-hot.
  - If req is all zero, gnt is all zero.
- A transfer occurs at the edge where req[i] && gnt[i]. On that edge:
  - q <= wdata[i];
  - owner <= i;
  - ptr <= i;
  - q_valid <= 1.
- No transfer at an edge: q and owner hold; q_valid <= 0.
- Requesters may change req freely. A requester that drops req before an edge simply loses that slot; no transfer occurs for it.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,N_REQ−1,0,…. No requester waits more than N_REQ−1 transfers.
- Reset (synchronous, any time, including mid-lock):
  - q=0, q_valid=0, owner=0.
  - ptr=N_REQ−1, so requester 0 has top priority on the first cycle after reset.
  - lock_active=0, lock_cnt=0.
  - While reset is high, gnt is forced to 0 and no transfer occurs.

## Timing
- gnt is valid in the same cycle as req; zero-cycle arbitration latency.
- Write latency is one cycle: q, owner and q_valid reflect a transfer on the cycle after the grant edge.
- Back-to-back transfers are allowed every cycle, giving throughput of one write per clock.
- Simultaneous requests are resolved purely by ptr rotation; there is no fixed priority except immediately after reset.

## Configuration
- Macro ARB_LOCK_EN.
- Defined:
  - lock port exists.
  - On a transfer by requester i with lock[i]=1: set lock_active, lock_cnt <= lock_cnt+1.
  - While lock_active && req[i] && lock[i] && lock_cnt < MAX_LOCK: gnt is forced to i regardless of other requests.
  - The lock releases when any of these holds: req[i]=0, lock[i]=0, or lock_cnt reaches MAX_LOCK.
  - On release: lock_active=0, lock_cnt=0, and normal round-robin applies in that same cycle, starting from ptr+1.
  - A requester therefore holds the register for at most MAX_LOCK consecutive transfers.
- Not defined: no lock port and no lock state; pure round-robin.

## Structure
- Package reg_arbiter_pkg holds:
  - default parameter constants;
  - the idx_t typedef for owner and ptr width;
  - the function next_idx(ptr, N) for wrap-around.
- One sub-module, rr_pick:
  - purely combinational;
  - inputs req and ptr;
  - outputs one-hot gnt and the winning index.
- Register updates (q, owner, ptr, lock state) live in reg_arbiter in a single always_ff block.

## Test plan
- Reset check: assert reset with req=4'b1111 → gnt=0, q=0, owner=0, q_valid=0. Release reset → first gnt=4'b0001.
- Rotation: req=4'b1111 continuously, wdata[i]=8'h10+i → owner sequence 0,1,2,3,0 with q=8'h10,11,12,13,10 and q_valid high every cycle.
- Sparse requests and wrap-around: ptr=2, req=4'b0011 → gnt=4'b0001, then gnt=4'b0010 on the next cycle.
- Idle: req=0 for 3 cycles after a write of 8'hA5 → q holds 8'hA5, q_valid=0, gnt=0.
- Lock (ARB_LOCK_EN, MAX_LOCK=4): requester 1 holds req and lock with others requesting → exactly 4 consecutive grants to 1, then a grant to 2.
- Reset mid-lock: assert reset during locked grant 2 of 4 → lock cleared; after release, the grant order restarts at requester 0.

Source files
------------

// File: rtl/reg_arbiter_pkg.sv
// reg_arbiter_pkg: shared defaults, index type and wrap-around helper for reg_arbiter.
package reg_arbiter_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_LOCK_DEF = 4;
  typedef logic [$clog2(N_REQ_DEF)-1:0] idx_t;
  function automatic int next_idx(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; first set req bit after ptr (wrapping) wins.
// Ports: req (requests), ptr (last granted index) -> gnt (one-hot or zero), idx (winner index).
import reg_arbiter_pkg::*;
module rr_pick #(
  parameter int N = N_REQ_DEF,
  parameter int IW = $clog2(N_REQ_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    int j;
    logic found;
    gnt = '0;
    idx = '0;
    found = 1'b0;
    j = next_idx(int'(ptr), N);
    for (int k = 0; k < N; k++) begin
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx = IW'(j);
        found = 1'b1;
      end
      j = next_idx(j, N);
    end
  end
endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
// Ports: clk, reset (sync, active-high), req, wdata[i] per requester, lock (ARB_LOCK_EN only),
//        gnt (combinational one-hot), q (shared register), q_valid (pulse after a write),
//        owner (index whose data is in q).
// Optional macro ARB_LOCK_EN: lets the last granted requester hold the register for up to
// MAX_LOCK consecutive transfers.
import reg_arbiter_pkg::*;
module reg_arbiter #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0][WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]            lock,
`endif
  output logic [N_REQ-1:0]            gnt,
  output logic [WIDTH-1:0]            q,
  output logic                        q_valid,
  output logic [$clog2(N_REQ)-1:0]    owner
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr, rr_idx, win;
  logic [N_REQ-1:0] rr_gnt;
  logic hold, xfer;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (.req(req), .ptr(ptr), .gnt(rr_gnt), .idx(rr_idx));
`ifdef ARB_LOCK_EN
  localparam int LW = $clog2(MAX_LOCK + 1);
  logic lock_active;
  logic [LW-1:0] lock_cnt;
  // the lock holder is always the last granted requester, so ptr names it
  assign hold = lock_active && req[ptr] && lock[ptr] && lock_cnt < LW'(MAX_LOCK);
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    gnt = reset ? '0 : hold ? (N_REQ'(1) << ptr) : rr_gnt;
    win = hold ? ptr : rr_idx;
    xfer = |gnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
      q_valid <= 1'b0;
      owner <= '0;
      ptr <= IW'(N_REQ - 1);
`ifdef ARB_LOCK_EN
      lock_active <= 1'b0;
      lock_cnt <= '0;
`endif
    end else begin
      q_valid <= xfer;
      if (xfer) begin
        q <= wdata[win];
        owner <= win;
        ptr <= win;
      end
`ifdef ARB_LOCK_EN
      // a fresh lock (after release or from round-robin) restarts counting at 1
      lock_active <= xfer && lock[win];
      lock_cnt <= (xfer && lock[win]) ? (hold ? lock_cnt : LW'(0)) + LW'(1) : '0;
`endif
    end
  end
endmodule
